// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM states, round constants,
// round-key type and the GF(2^8) multiply used by the S-box.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int NR = 10;

    // Bit 0 is the MSB of byte 0, matching the FIPS-197 byte stream order.
    typedef logic [0:127] rk_t;

    localparam logic [7:0] RCON [1:NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/key_expand_ctrl_if.sv
// Key-load / round-key read bus between the key sequencer and its consumer.
interface key_expand_ctrl_if;

    logic             start;
    aes_pkg::rk_t     key_in;
    logic             busy;
    logic             done;
    logic             keys_valid;
    logic [3:0]       rk_addr;
    aes_pkg::rk_t     rk_out;

    modport slave (
        input  start, key_in, rk_addr,
        output busy, done, keys_valid, rk_out
    );

    modport master (
        output start, key_in, rk_addr,
        input  busy, done, keys_valid, rk_out
    );

endinterface

// File: rtl/aes_key_round.sv
// One combinational AES-128 key-schedule round: RK[r-1], rcon(r) -> RK[r].
module aes_key_round
    import aes_pkg::*;
(
    input  rk_t        i_prev_key,
    input  logic [7:0] i_rcon,
    output rk_t        o_next_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_g;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0  = i_prev_key[0:31];
    assign w_w1  = i_prev_key[32:63];
    assign w_w2  = i_prev_key[64:95];
    assign w_w3  = i_prev_key[96:127];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*gi +: 8]),
            .o_byte (w_sub[8*gi +: 8])
        );
    end

    assign w_g  = w_sub ^ {i_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_g;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_sq;
    logic [7:0] w_inv;

    // x^254 = x^-1 (and 0 -> 0) via seven square-and-multiply steps.
    always_comb begin
        w_sq  = i_byte;
        w_inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            w_sq  = gf_mul(w_sq, w_sq);
            w_inv = gf_mul(w_inv, w_sq);
        end
    end

    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion sequencer: one key round per clock into an 11-entry
// round-key file, read through a registered port by the round controller.
module key_expand_ctrl
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    key_expand_ctrl_if.slave  bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [3:0] r_round;
    rk_t        r_rk [0:NR];
    rk_t        r_rk_out;
    logic       r_done;
    logic       r_keys_valid;
    logic       w_accept;
    logic       w_write;
    logic       w_last;
    logic [7:0] w_rcon;
    rk_t        w_prev_key;
    rk_t        w_next_key;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_write = 1'b1;
                if (r_round == LAST_ROUND) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_last = w_write && (r_round == LAST_ROUND);

    // Counter is only in 1..NR while expanding; outside that the datapath idles on RK0.
    always_comb begin
        w_rcon     = 8'h00;
        w_prev_key = r_rk[0];
        if (r_round >= 4'd1 && r_round <= LAST_ROUND) begin
            w_rcon     = RCON[r_round];
            w_prev_key = r_rk[r_round - 4'd1];
        end
    end

    aes_key_round u_key_round (
        .i_prev_key (w_prev_key),
        .i_rcon     (w_rcon),
        .o_next_key (w_next_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_round      <= 4'd0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_round      <= 4'd1;
                r_keys_valid <= 1'b0;
            end else if (w_write) begin
                r_round <= r_round + 4'd1;
                if (w_last) r_keys_valid <= 1'b1;
            end
        end
    end

    // A restart overwrites entries in order; stale later entries stay until rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
        end else if (w_accept) begin
            r_rk[0] <= bus.key_in;
        end else if (w_write) begin
            r_rk[r_round] <= w_next_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_rk_out <= '0;
        else if (bus.rk_addr <= LAST_ROUND)  r_rk_out <= r_rk[bus.rk_addr];
        else                                 r_rk_out <= '0;
    end

    assign bus.busy       = (r_state == ST_EXPAND);
    assign bus.done       = r_done;
    assign bus.keys_valid = r_keys_valid;
    assign bus.rk_out     = r_rk_out;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Bench for key_expand_ctrl: FIPS-197 word-oriented key schedule model plus a
// cycle schedule of when each round key lands, compared on every falling edge.
module tb_key_expand_ctrl;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    key_expand_ctrl_if ifc ();

    key_expand_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    logic [7:0]   sb [0:255];
    logic [127:0] m_file [0:10];
    logic [127:0] m_key = '0;
    logic [127:0] m_rk_out = '0;
    int           m_next = 0;
    logic         m_done = 1'b0;
    logic         m_valid = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] expand_rk(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 4*(r+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Schedule model: RK0 on the accepting edge, RK[n] on the n-th edge after it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= 10; i++) m_file[i] = '0;
            m_next   = 0;
            m_done   = 1'b0;
            m_valid  = 1'b0;
            m_rk_out = '0;
        end else begin
            m_rk_out = (ifc.rk_addr <= 4'd10) ? m_file[ifc.rk_addr] : '0;
            m_done   = 1'b0;
            if (m_next >= 1 && m_next <= 10) begin
                m_file[m_next] = expand_rk(m_key, m_next);
                if (m_next == 10) begin
                    m_done  = 1'b1;
                    m_valid = 1'b1;
                end
                m_next++;
            end else if (ifc.start) begin
                m_key     = ifc.key_in;
                m_file[0] = ifc.key_in;
                m_next    = 1;
                m_valid   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",       {127'd0, ifc.busy},       {127'd0, (m_next >= 1 && m_next <= 10)});
        chk("done",       {127'd0, ifc.done},       {127'd0, m_done});
        chk("keys_valid", {127'd0, ifc.keys_valid}, {127'd0, m_valid});
        chk("rk_out",     ifc.rk_out,               m_rk_out);
    end

    task automatic launch(input logic [127:0] key);
        ifc.key_in = key;
        ifc.start  = 1'b1;
        @(negedge clk);
        ifc.start  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!ifc.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic read_rk(input int a, output logic [127:0] v);
        ifc.rk_addr = 4'(a);
        @(negedge clk);
        v = ifc.rk_out;
    endtask

    initial begin
        logic [7:0]   p, q, x;
        logic [127:0] v;
        logic [127:0] k2;
        int           cyc;

        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;

        ifc.start   = 1'b0;
        ifc.key_in  = '0;
        ifc.rk_addr = 4'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_busy",  {127'd0, ifc.busy},       128'd0);
        chk("reset_done",  {127'd0, ifc.done},       128'd0);
        chk("reset_valid", {127'd0, ifc.keys_valid}, 128'd0);
        chk("reset_rkout", ifc.rk_out,               128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("model_sbox00",  {120'd0, sb[8'h00]}, 128'h63);
        chk("model_sbox53",  {120'd0, sb[8'h53]}, 128'hed);
        chk("model_fips_rk1",  expand_rk(FIPS_KEY, 1),  FIPS_RK1);
        chk("model_fips_rk10", expand_rk(FIPS_KEY, 10), FIPS_RK10);
        chk("model_zero_rk10", expand_rk('0, 10),       ZERO_RK10);

        launch(FIPS_KEY);
        wait_done(cyc);
        chk("fips_latency", 128'(cyc), 128'd11);
        read_rk(1, v);  chk("fips_rk1", v, FIPS_RK1);
        read_rk(10, v); chk("fips_rk10", v, FIPS_RK10);
        read_rk(0, v);  chk("fips_rk0", v, FIPS_KEY);

        // A second start three cycles into the expansion must be dropped.
        launch(FIPS_KEY);
        cyc = 1;
        repeat (3) begin @(negedge clk); cyc++; end
        k2 = {$urandom, $urandom, $urandom, $urandom};
        ifc.key_in = k2;
        ifc.start  = 1'b1;
        @(negedge clk);
        cyc++;
        ifc.start  = 1'b0;
        while (!ifc.done && cyc < 40) begin @(negedge clk); cyc++; end
        chk("ignored_latency", 128'(cyc), 128'd11);
        read_rk(10, v); chk("ignored_rk10", v, FIPS_RK10);

        launch(FIPS_KEY);
        wait_done(cyc);
        launch('0);
        chk("b2b_valid_drop", {127'd0, ifc.keys_valid}, 128'd0);
        chk("b2b_busy",       {127'd0, ifc.busy},       128'd1);
        wait_done(cyc);
        chk("b2b_latency", 128'(cyc), 128'd11);
        read_rk(10, v); chk("b2b_rk10", v, ZERO_RK10);

        launch({$urandom, $urandom, $urandom, $urandom});
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  {127'd0, ifc.busy},       128'd0);
        chk("arst_done",  {127'd0, ifc.done},       128'd0);
        chk("arst_valid", {127'd0, ifc.keys_valid}, 128'd0);
        chk("arst_rkout", ifc.rk_out,               128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(FIPS_KEY);
        wait_done(cyc);
        chk("arst_latency", 128'(cyc), 128'd11);
        read_rk(10, v); chk("arst_rk10", v, FIPS_RK10);

        for (int a = 0; a < 16; a++) begin
            read_rk(a, v);
            chk($sformatf("sweep_rk%0d", a), v, (a <= 10) ? expand_rk(FIPS_KEY, a) : 128'd0);
        end

        repeat (400) begin
            ifc.key_in  = {$urandom, $urandom, $urandom, $urandom};
            ifc.start   = ($urandom_range(0, 11) == 0);
            ifc.rk_addr = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        ifc.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
